// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg: shared definitions for the uio bus arbiter.
//   - UIO_W       : width of the bidirectional uio pin bank.
//   - arb_state_e : arbiter FSM state encoding (IDLE / TURN / GRANT).
//   - rot_idx()   : round-robin index helper, (base + off) wrapped into [0, n).
package uio_arb_pkg;

  localparam int UIO_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    GRANT = 2'd2
  } arb_state_e;

  // base and off are both < n, so a single conditional subtract wraps the sum.
  function automatic int unsigned rot_idx(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner select.
//   req   [NREQ-1:0]  : request vector.
//   ptr   [IDX_W-1:0] : highest-priority index for this pick.
//   valid             : at least one request is set.
//   idx   [IDX_W-1:0] : first set request at or after ptr, wrapping.
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the lowest priority to the highest so the last hit, i.e. the
  // request closest to ptr, is the one that sticks.
  always_comb begin
    valid = |req;
    idx   = ptr;
    cand  = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDX_W'(rot_idx(32'(ptr), 32'(k), 32'(NREQ)));
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: shares the 8-bit uio pin bank between NREQ requesters.
// Grants are round-robin, one owner at a time, with a turnaround gap of
// all-zero output enables between owners. Pad outputs are fully registered.
//   clk, rst_n         : clock, asynchronous active-low reset.
//   ena                : global enable; low releases the bank and blocks grants.
//   req / req_dir      : per-requester request and direction (1 = drive pins).
//   req_data           : per-requester output byte, requester i at [8i+7:8i].
//   gnt                : one-hot registered grant.
//   rd_data / rd_valid : uio_in captured while a read-direction owner holds the bank.
//   uio_in / uio_out / uio_oe : pad interface (all oe bits equal).
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [UIO_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [UIO_W-1:0]      rd_data,
  output logic                  rd_valid,
  input  logic [UIO_W-1:0]      uio_in,
  output logic [UIO_W-1:0]      uio_out,
  output logic [UIO_W-1:0]      uio_oe
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  W_LAST    = IDX_W'(NREQ - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  w_q, w_d;
  logic              dir_q, dir_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]        turn_cnt_q, turn_cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [UIO_W-1:0]  uio_out_q, uio_out_d;
  logic [UIO_W-1:0]  uio_oe_q, uio_oe_d;
  logic [UIO_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic [UIO_W-1:0]  data_arr [NREQ];
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              go_grant;
  logic [IDX_W-1:0]  w_new;
  logic              dir_new;
  logic [NREQ-1:0]   others;
  logic              rel_now;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_data
      assign data_arr[gi] = req_data[UIO_W*gi +: UIO_W];
    end
  endgenerate

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    dir_d      = dir_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    gnt_d      = gnt_q;
    uio_out_d  = uio_out_q;
    uio_oe_d   = uio_oe_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    go_grant   = 1'b0;
    w_new      = w_q;
    dir_new    = dir_q;

    // Any requester other than the current owner waiting for the bank.
    others  = req & ~(NREQ'(1) << w_q);
    rel_now = !req[w_q] || !ena || ((hold_cnt_q == HOLD_LAST) && (|others));

    case (state_q)
      IDLE: begin
        gnt_d      = '0;
        uio_oe_d   = '0;
        uio_out_d  = '0;
        rd_valid_d = 1'b0;
        hold_cnt_d = '0;
        turn_cnt_d = '0;
        if (ena && pick_valid) begin
          if (TURN_CYC == 0) begin
            go_grant = 1'b1;
            w_new    = pick_idx;
            dir_new  = req_dir[pick_idx];
          end else begin
            state_d    = TURN;
            w_d        = pick_idx;
            dir_d      = req_dir[pick_idx];
            turn_cnt_d = 3'(TURN_CYC);
          end
        end
      end

      TURN: begin
        // Winner and direction are frozen here; only ena can abort.
        if (!ena) begin
          state_d    = IDLE;
          turn_cnt_d = '0;
        end else if (turn_cnt_q <= 3'd1) begin
          go_grant   = 1'b1;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q - 3'd1;
        end
      end

      GRANT: begin
        if (rel_now) begin
          state_d    = IDLE;
          gnt_d      = '0;
          uio_oe_d   = '0;
          uio_out_d  = '0;
          rd_valid_d = 1'b0;
          hold_cnt_d = '0;
          rr_ptr_d   = (w_q == W_LAST) ? '0 : w_q + IDX_W'(1);
        end else begin
          if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (dir_q) begin
            uio_oe_d  = '1;
            uio_out_d = data_arr[w_q];
          end else begin
            uio_oe_d   = '0;
            uio_out_d  = '0;
            rd_data_d  = uio_in;
            rd_valid_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Common entry into GRANT, reached from TURN or directly from IDLE when
    // there is no turnaround. gnt and pin drive appear on the entry edge.
    if (go_grant) begin
      state_d        = GRANT;
      w_d            = w_new;
      dir_d          = dir_new;
      gnt_d          = '0;
      gnt_d[w_new]   = 1'b1;
      hold_cnt_d     = '0;
      rd_valid_d     = 1'b0;
      if (dir_new) begin
        uio_oe_d  = '1;
        uio_out_d = data_arr[w_new];
      end else begin
        uio_oe_d  = '0;
        uio_out_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      w_q        <= '0;
      dir_q      <= 1'b0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      gnt_q      <= '0;
      uio_out_q  <= '0;
      uio_oe_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      dir_q      <= dir_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      gnt_q      <= gnt_d;
      uio_out_q  <= uio_out_d;
      uio_oe_q   <= uio_oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign gnt      = gnt_q;
  assign uio_out  = uio_out_q;
  assign uio_oe   = uio_oe_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: directed scoreboard bench for uio_bus_arbiter
// (NREQ=4, MAX_HOLD=16, TURN_CYC=1). Each directed step pushes the per-edge
// expected outputs, then the queue is drained one clock edge per entry.
module tb_uio_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  req_dir;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  int vectors     = 0;
  int miscompares = 0;
  int step_no     = 0;
  string cur_test = "none";

  typedef struct {
    logic [3:0] g;
    logic [7:0] oe;
    logic [7:0] out;
    logic       rdv;
    logic [7:0] rdd;
    bit         chk_rdd;
  } exp_t;

  exp_t sb_q[$];

  uio_bus_arbiter #(
    .NREQ     (4),
    .MAX_HOLD (16),
    .TURN_CYC (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .req      (req),
    .req_dir  (req_dir),
    .req_data (req_data),
    .gnt      (gnt),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .uio_in   (uio_in),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s/%s step %0d: observed %h expected %h", cur_test, tag, step_no, obs, exp_v);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] oe, input logic [7:0] out,
                      input logic rdv, input logic [7:0] rdd, input bit crd);
    exp_t e;
    e.g = g; e.oe = oe; e.out = out; e.rdv = rdv; e.rdd = rdd; e.chk_rdd = crd;
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(4'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic push_drive(input int n, input logic [3:0] g, input logic [7:0] out);
    for (int i = 0; i < n; i++) push(g, 8'hFF, out, 1'b0, 8'h00, 1'b0);
  endtask

  // One clock edge per queued entry; outputs sampled 1 time unit after the edge.
  task automatic run_sb();
    exp_t e;
    while (sb_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      step_no++;
      chk("gnt",      8'(gnt),      8'(e.g));
      chk("uio_oe",   uio_oe,       e.oe);
      chk("uio_out",  uio_out,      e.out);
      chk("rd_valid", 8'(rd_valid), 8'(e.rdv));
      if (e.chk_rdd) chk("rd_data", rd_data, e.rdd);
      $display("[%s] step %0d gnt=%b oe=%h out=%h rdv=%b rdd=%h",
               cur_test, step_no, gnt, uio_oe, uio_out, rd_valid, rd_data);
    end
  endtask

  // Reset released 1 time unit after an edge, so the next edge is "edge 1".
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",  8'(gnt),      8'h00);
    chk("rst_oe",   uio_oe,       8'h00);
    chk("rst_out",  uio_out,      8'h00);
    chk("rst_rdv",  8'(rd_valid), 8'h00);
    chk("rst_rdd",  rd_data,      8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    req      = 4'b1111;
    req_dir  = 4'b1111;
    req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA5};
    uio_in   = 8'h00;

    // Reset with every requester asking: requester 0 wins at edge 2.
    cur_test = "reset";
    do_reset();
    push_idle(1);
    push_drive(1, 4'b0001, 8'hA5);
    run_sb();
    req = 4'b0000;
    push_idle(2);
    run_sb();

    // Two contenders alternate on hold expiry with a 2-cycle oe=0 gap.
    cur_test = "rr_hold";
    req = 4'b0101;
    do_reset();
    push_idle(1);
    push_drive(16, 4'b0001, 8'hA5);
    push_idle(2);
    push_drive(16, 4'b0100, 8'hC3);
    push_idle(2);
    push_drive(1, 4'b0001, 8'hA5);
    run_sb();
    req = 4'b0000;
    push_idle(2);
    run_sb();

    // Read-direction owner: pins stay released, uio_in captured each cycle.
    cur_test = "read";
    req_dir = 4'b1101;
    req     = 4'b0010;
    uio_in  = 8'h3C;
    push_idle(1);
    push(4'b0010, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    push(4'b0010, 8'h00, 8'h00, 1'b1, 8'h3C, 1'b1);
    run_sb();
    uio_in = 8'h5A;
    push(4'b0010, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b1);
    run_sb();
    req = 4'b0000;
    push_idle(2);
    run_sb();
    req_dir = 4'b1111;

    // Lone requester keeps the bank past MAX_HOLD; data change shows 1-cycle latency.
    cur_test = "lone";
    req = 4'b0001;
    push_idle(1);
    push_drive(20, 4'b0001, 8'hA5);
    run_sb();
    req_data[7:0] = 8'h5A;
    push_drive(20, 4'b0001, 8'h5A);
    run_sb();
    req = 4'b0000;
    req_data[7:0] = 8'hA5;
    push_idle(2);
    run_sb();

    // ena drop mid-GRANT releases; no grants while low; resumes from rr_ptr.
    cur_test = "ena";
    req = 4'b0110;
    push_idle(1);
    push_drive(2, 4'b0010, 8'hB2);
    run_sb();
    ena = 1'b0;
    push_idle(5);
    run_sb();
    ena = 1'b1;
    push_idle(1);
    push_drive(1, 4'b0100, 8'hC3);
    run_sb();
    req = 4'b0000;
    push_idle(2);
    run_sb();
    // ena drop during TURN aborts the grant.
    req = 4'b1000;
    push_idle(1);
    run_sb();
    ena = 1'b0;
    push_idle(2);
    run_sb();
    ena = 1'b1;
    push_idle(1);
    push_drive(1, 4'b1000, 8'hD4);
    run_sb();

    // Asynchronous reset while driving: pins released without a clock edge.
    cur_test = "async_rst";
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_oe",  uio_oe,       8'h00);
    chk("arst_out", uio_out,      8'h00);
    chk("arst_gnt", 8'(gnt),      8'h00);
    chk("arst_rdv", 8'(rd_valid), 8'h00);
    $display("[%s] gnt=%b oe=%h out=%h", cur_test, gnt, uio_oe, uio_out);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
